// File: rtl/rrat_commit.sv
// rrat_commit: retirement RAT and physical-register reclaim for one thread.
//
// Commit side: up to two retiring instructions per cycle (head, head_plus1).
// Each one updates the architectural-to-physical map. The PRN it displaces
// is queued for the free list.
// Recovery side: a ROB nuke streams the committed map back to the front-end
// RAT, two ARNs per cycle.
//
// Optional feature macro: RRAT_ZERO_REG_EN. When it is defined, the all-ones
// ARN acts as a hardwired zero register. Its map entry never changes, and a
// commit to it returns its own PRN_dest to the free list.
//
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   head, head_plus1        commit slots 0 and 1 (slot 1 is younger)
//   nuke                    ROB flush, aligned with the head fields
//   free_valid/_2, free_prn_0/1, free_ready
//                           freed-PRN handshake, oldest entry first
//   recovering, recov_valid, recov_arn_0/1, recov_prn_0/1, recov_done
//                           committed-map recovery stream
//   overflow, proto_err     sticky error flags
//
// ARN_BITS and PRN_BITS can be overridden on the command line.

`ifndef ARN_BITS
`define ARN_BITS 5
`endif
`ifndef PRN_BITS
`define PRN_BITS 7
`endif

package rrat_pkg;
    localparam int ARN_BITS = `ARN_BITS;
    localparam int PRN_BITS = `PRN_BITS;

    typedef struct packed {
        logic                committed;
        logic [ARN_BITS-1:0] ARN_dest;
        logic [PRN_BITS-1:0] PRN_dest;
    } rob_rrat_t;
endpackage

module rrat_commit
    import rrat_pkg::*;
#(
    parameter int THREAD_ID    = 0,
    parameter int FREE_Q_DEPTH = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  rob_rrat_t           head,
    input  rob_rrat_t           head_plus1,
    input  logic                nuke,
    output logic                free_valid,
    output logic                free_valid_2,
    output logic [PRN_BITS-1:0] free_prn_0,
    output logic [PRN_BITS-1:0] free_prn_1,
    input  logic                free_ready,
    output logic                recovering,
    output logic                recov_valid,
    output logic [ARN_BITS-1:0] recov_arn_0,
    output logic [ARN_BITS-1:0] recov_arn_1,
    output logic [PRN_BITS-1:0] recov_prn_0,
    output logic [PRN_BITS-1:0] recov_prn_1,
    output logic                recov_done,
    output logic                overflow,
    output logic                proto_err
);
    localparam int AW    = ARN_BITS;
    localparam int PW    = PRN_BITS;
    localparam int N_ARN = 1 << AW;
    localparam int QAW   = $clog2(FREE_Q_DEPTH);
    localparam int CW    = QAW + 1;

`ifdef RRAT_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    if (FREE_Q_DEPTH < 4 || (FREE_Q_DEPTH & (FREE_Q_DEPTH - 1)) != 0 || THREAD_ID < 0) begin : g_bad_cfg
        $error("rrat_commit: FREE_Q_DEPTH must be a power of two >= 4");
    end

    typedef enum logic [1:0] {IDLE, RECOVER, DONE} state_t;

    logic [PW-1:0] map_q [N_ARN];
    logic [PW-1:0] map_d [N_ARN];
    logic [PW-1:0] mem_q [FREE_Q_DEPTH];
    logic [CW-1:0] count_q;
    logic [QAW-1:0] rd_q, wr_q;
    state_t        state_q, state_d;
    logic [AW-2:0] k_q, k_d;

    logic [1:0]    push_cnt, pop_n, acc;
    logic [PW-1:0] push_a, push_b;
    logic [CW-1:0] after_pop, space;
    logic          drop, proto_set;
    logic          zr0, zr1;

    // Commit: slot 1 only retires behind slot 0, and it sees slot 0's map
    // update. A same-ARN pair therefore frees the old value and then
    // head.PRN_dest.
    always_comb begin
        map_d    = map_q;
        push_cnt = 2'd0;
        push_a   = '0;
        push_b   = '0;
        zr0      = ZERO_REG_EN && (&head.ARN_dest);
        zr1      = ZERO_REG_EN && (&head_plus1.ARN_dest);
        if (head.committed) begin
            push_cnt = 2'd1;
            if (zr0) begin
                push_a = head.PRN_dest;
            end else begin
                push_a = map_d[head.ARN_dest];
                map_d[head.ARN_dest] = head.PRN_dest;
            end
            if (head_plus1.committed) begin
                push_cnt = 2'd2;
                if (zr1) begin
                    push_b = head_plus1.PRN_dest;
                end else begin
                    push_b = map_d[head_plus1.ARN_dest];
                    map_d[head_plus1.ARN_dest] = head_plus1.PRN_dest;
                end
            end
        end
    end

    // Free queue: the pop is taken first. Whatever the pushes cannot fit is
    // dropped from the youngest end.
    always_comb begin
        pop_n = 2'd0;
        if (free_ready) begin
            if (count_q >= CW'(2))      pop_n = 2'd2;
            else if (count_q != '0)     pop_n = 2'd1;
        end
        after_pop = count_q - {{(CW-2){1'b0}}, pop_n};
        space     = CW'(FREE_Q_DEPTH) - after_pop;
        drop      = {{(CW-2){1'b0}}, push_cnt} > space;
        acc       = drop ? space[1:0] : push_cnt;
    end

    assign proto_set = (head_plus1.committed && !head.committed) ||
                       ((head.committed || head_plus1.committed) && state_q != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ARN; i++) map_q[i] <= PW'(i);
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            map_q   <= map_d;
            count_q <= after_pop + {{(CW-2){1'b0}}, acc};
            rd_q    <= rd_q + QAW'(pop_n);
            wr_q    <= wr_q + QAW'(acc);
            if (drop)      overflow  <= 1'b1;
            if (proto_set) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (acc != 2'd0) mem_q[wr_q] <= push_a;
        if (acc == 2'd2) mem_q[wr_q + QAW'(1)] <= push_b;
    end

    assign free_valid   = count_q != '0;
    assign free_valid_2 = count_q >= CW'(2);
    assign free_prn_0   = free_valid   ? mem_q[rd_q] : '0;
    assign free_prn_1   = free_valid_2 ? mem_q[rd_q + QAW'(1)] : '0;

    // Recovery FSM
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (nuke) begin
                    state_d = RECOVER;
                    k_d     = '0;
                end
            end
            RECOVER: begin
                if (nuke) begin
                    k_d = '0;
                end else if (&k_q) begin
                    state_d = DONE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                state_d = nuke ? RECOVER : IDLE;
                k_d     = '0;
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // The stream reads map_q directly. Commits made in the nuke cycle are
    // already in the map by the first pair. Later commits reach only the
    // pairs that have not been streamed yet.
    assign recovering  = state_q != IDLE;
    assign recov_valid = state_q == RECOVER;
    assign recov_done  = state_q == DONE;
    assign recov_arn_0 = recov_valid ? {k_q, 1'b0} : '0;
    assign recov_arn_1 = recov_valid ? {k_q, 1'b1} : '0;
    assign recov_prn_0 = recov_valid ? map_q[{k_q, 1'b0}] : '0;
    assign recov_prn_1 = !recov_valid ? '0 :
                         (ZERO_REG_EN && (&k_q)) ? PW'({AW{1'b1}}) :
                         map_q[{k_q, 1'b1}];
endmodule
